// File: rtl/sfu_pkg.sv
// sfu_pkg: shared constants and the 2^f correction table for the SFU exp2 path.
//   CORR_LUT[i] = round(65536*((1+i/32) - 2^(i/32))), Q0.16, i = 0..31.
//   corr_at(i) reads the table with a 6-bit index; index 32 is the
//   interpolation end point and returns 0.
package sfu_pkg;
  localparam int CORR_W    = 16;
  localparam int MANT_FRAC = 16;
  localparam int LUT_IDX_W = 5;
  localparam logic [CORR_W-1:0] CORR_LUT [32] = '{
    16'd0,    16'd613,  16'd1194, 16'd1744, 16'd2260, 16'd2744, 16'd3192, 16'd3606,
    16'd3984, 16'd4326, 16'd4630, 16'd4895, 16'd5122, 16'd5309, 16'd5456, 16'd5560,
    16'd5622, 16'd5641, 16'd5615, 16'd5543, 16'd5426, 16'd5261, 16'd5047, 16'd4784,
    16'd4470, 16'd4105, 16'd3686, 16'd3214, 16'd2686, 16'd2103, 16'd1461, 16'd761
  };
  function automatic logic [CORR_W-1:0] corr_at(input logic [LUT_IDX_W:0] i);
    return i[LUT_IDX_W] ? '0 : CORR_LUT[i[LUT_IDX_W-1:0]];
  endfunction
endpackage

// File: rtl/sfu_exp2_corr_rom.sv
// sfu_exp2_corr_rom: dual-read correction ROM with registered outputs.
//   clk, rst_n : clock, asynchronous active-low reset (outputs clear to 0)
//   en         : outputs update only when high (pipeline stall hold)
//   idx_a      : segment index 0..31        -> corr_a
//   idx_b      : segment end index 1..32    -> corr_b (32 reads as 0)
module sfu_exp2_corr_rom
  import sfu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [LUT_IDX_W-1:0] idx_a,
  input  logic [LUT_IDX_W:0]   idx_b,
  output logic [CORR_W-1:0]    corr_a,
  output logic [CORR_W-1:0]    corr_b
);
  logic [CORR_W-1:0] corr_a_q, corr_a_d, corr_b_q, corr_b_d;
  always_comb begin
    corr_a_d = corr_at({1'b0, idx_a});
    corr_b_d = corr_at(idx_b);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      corr_a_q <= '0;
      corr_b_q <= '0;
    end else if (en) begin
      corr_a_q <= corr_a_d;
      corr_b_q <= corr_b_d;
    end
  assign corr_a = corr_a_q;
  assign corr_b = corr_b_q;
endmodule

// File: rtl/sfu_exp2_unit.sv
// sfu_exp2_unit: 3-stage fixed-point 2^x with valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready drops only while the output stalls
//   in_x                : signed Q(IN_INT).(IN_FRAC) exponent
//   in_tag              : sideband returned with the result
//   out_valid/out_ready : output handshake
//   out_y               : unsigned Q(OUT_WIDTH-OUT_FRAC).OUT_FRAC, saturates to all ones
//   out_tag             : tag of out_y
// S1 splits x and reads the ROM, S2 interpolates the mantissa 2^f in Q1.16,
// S3 shifts by n and saturates.
module sfu_exp2_unit
  import sfu_pkg::*;
#(
  parameter int IN_INT    = 5,
  parameter int IN_FRAC   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_FRAC  = 16,
  parameter int TAG_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_INT+IN_FRAC-1:0] in_x,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_y,
  output logic [TAG_W-1:0]          out_tag
);
  localparam int IN_W = IN_INT + IN_FRAC;
  localparam int RW   = (IN_FRAC > LUT_IDX_W) ? IN_FRAC - LUT_IDX_W : 1;
  localparam int PW   = RW + CORR_W + 2;
  logic                       en;
  logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [IN_INT-1:0]   n1_q, n1_d, n2_q, n2_d;
  logic [IN_FRAC-1:0]         f1_q, f1_d;
  logic [RW-1:0]              r1_q, r1_d;
  logic [TAG_W-1:0]           tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [MANT_FRAC:0]         m2_q, m2_d;
  logic [OUT_WIDTH-1:0]       y3_q, y3_d;
  logic [LUT_IDX_W-1:0]       idx;
  logic [LUT_IDX_W:0]         idx_b;
  logic [CORR_W-1:0]          corr_a, corr_b;
  logic signed [CORR_W:0]     delta;
  logic signed [PW-1:0]       prod, c;
  logic [IN_FRAC+MANT_FRAC-1:0] fa;
  logic [PW-1:0]              m_w;
  logic signed [15:0]         sh;
  logic                       sat;
  logic [OUT_WIDTH+MANT_FRAC:0] mw;
  assign en        = !(v3_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_y     = y3_q;
  assign out_tag   = tag3_q;
  always_comb begin
    idx    = in_x[IN_FRAC-1 -: LUT_IDX_W];
    idx_b  = {1'b0, idx} + {{LUT_IDX_W{1'b0}}, 1'b1};
    v1_d   = in_valid;
    n1_d   = in_x[IN_W-1:IN_FRAC];
    f1_d   = in_x[IN_FRAC-1:0];
    r1_d   = IN_FRAC > LUT_IDX_W ? in_x[RW-1:0] : '0;
    tag1_d = in_tag;
  end
  sfu_exp2_corr_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .idx_a  (idx),
    .idx_b  (idx_b),
    .corr_a (corr_a),
    .corr_b (corr_b)
  );
  // Interpolated correction; the arithmetic shift floors a negative slope term.
  always_comb begin
    delta  = $signed({1'b0, corr_b}) - $signed({1'b0, corr_a});
    prod   = PW'(delta) * $signed({{(PW-RW){1'b0}}, r1_q});
    c      = (prod >>> RW) + $signed({{(PW-CORR_W){1'b0}}, corr_a});
    fa     = {f1_q, {MANT_FRAC{1'b0}}} >> IN_FRAC;
    m_w    = PW'(1 << MANT_FRAC) + PW'(fa) - c;
    m2_d   = m_w[MANT_FRAC:0];
    n2_d   = n1_q;
    v2_d   = v1_q;
    tag2_d = tag1_q;
  end
  // Mantissa m in [1,2) never needs more than OUT_WIDTH bits once unsaturated.
  always_comb begin
    sh     = 16'(n2_q) + 16'(OUT_FRAC - MANT_FRAC);
    sat    = 16'(n2_q) > $signed(16'(OUT_WIDTH - OUT_FRAC - 1));
    mw     = (OUT_WIDTH+MANT_FRAC+1)'(m2_q);
    y3_d   = sat ? '1 : sh < 0 ? OUT_WIDTH'(mw >> (-sh)) : OUT_WIDTH'(mw << sh);
    v3_d   = v2_q;
    tag3_d = tag2_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      n1_q <= '0; n2_q <= '0; f1_q <= '0; r1_q <= '0; m2_q <= '0; y3_q <= '0;
      tag1_q <= '0; tag2_q <= '0; tag3_q <= '0;
    end else if (en) begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      n1_q <= n1_d; n2_q <= n2_d; f1_q <= f1_d; r1_q <= r1_d; m2_q <= m2_d; y3_q <= y3_d;
      tag1_q <= tag1_d; tag2_q <= tag2_d; tag3_q <= tag3_d;
    end
endmodule
